// File: rtl/quad_encoder_counter_if.sv
// Pin-side and user-side signals of the quadrature encoder decoder.
// The decoder connects through the slave modport; whoever drives the
// encoder pins and consumes the position uses the master modport.
interface quad_encoder_counter_if #(
   parameter int COUNT_W = 8
);
   logic               i_a;
   logic               i_b;
   logic               i_btn;
   logic [1:0]         i_mode;
   logic               i_clr;
   logic [COUNT_W-1:0] o_count;
   logic               o_step;
   logic               o_dir;
   logic               o_btn_press;
   logic               o_err;

   modport master (
      output i_a, i_b, i_btn, i_mode, i_clr,
      input  o_count, o_step, o_dir, o_btn_press, o_err
   );

   modport slave (
      input  i_a, i_b, i_btn, i_mode, i_clr,
      output o_count, o_step, o_dir, o_btn_press, o_err
   );
endinterface

// File: rtl/quad_encoder_counter.sv
// Quadrature rotary-encoder decoder with push button.
// Each pin is synchronised, debounced, then registered once more so that
// the decoder always compares two registered quadrature states. Pin-to-output
// latency is DEB_CYCLES+3 clocks.
module quad_encoder_counter #(
   parameter int          COUNT_W    = 8,
   parameter int          DEB_CYCLES = 1000,
   parameter int          SATURATE   = 0,
   parameter int unsigned MAX_COUNT  = (1 << COUNT_W) - 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   quad_encoder_counter_if.slave   bus
);
   localparam int                 DEB_W    = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [COUNT_W-1:0] MAX_C    = COUNT_W'(MAX_COUNT);

   // Channel index: 0 = B, 1 = A, 2 = button
   logic [2:0]       w_raw;
   logic [2:0]       r_sync1, r_sync2, r_db;
   logic [DEB_W-1:0] r_deb_cnt [3];

   logic [1:0]         r_q, r_q_prev, r_mode;
   logic               r_btn_q, r_btn_prev;
   logic signed [3:0]  r_sub;
   logic [COUNT_W-1:0] r_count;
   logic               r_step, r_dir, r_press, r_err;

   logic [1:0]         w_change;
   logic               w_single, w_illegal, w_up, w_mode_chg, w_event;
   logic signed [3:0]  w_sub_step, w_sub_next, w_sub_d;
   logic [COUNT_W-1:0] w_count_next;

   // Gray position along the increment sequence 11 -> 10 -> 00 -> 01
   function automatic logic [1:0] gray_pos(input logic [1:0] q);
      case (q)
         2'b11:   return 2'd0;
         2'b10:   return 2'd1;
         2'b00:   return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   assign w_raw = {bus.i_btn, bus.i_a, bus.i_b};

   // Two-flop synchronisers, idle-high reset so no spurious edge after reset
   // NOTE: state is updated with <= so every flop samples pre-edge values;
   // blocking here would collapse the two synchroniser stages into one.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Debouncers: toggle after DEB_CYCLES consecutive disagreeing samples
   // NOTE: the counter array is a handful of flops, not a RAM, so it is reset
   // like any other register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_db <= '1;
         for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_deb_cnt[i] <= '0;
            end else if (r_deb_cnt[i] == DEB_LAST) begin
               r_db[i]      <= ~r_db[i];
               r_deb_cnt[i] <= '0;
            end else begin
               r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
            end
         end
      end
   end

   // Register debounced levels and keep their previous values for edge detect
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q        <= 2'b11;
         r_q_prev   <= 2'b11;
         r_btn_q    <= 1'b1;
         r_btn_prev <= 1'b1;
         r_mode     <= 2'd0;
      end else begin
         r_q        <= r_db[1:0];
         r_q_prev   <= r_q;
         r_btn_q    <= r_db[2];
         r_btn_prev <= r_btn_q;
         r_mode     <= bus.i_mode;
      end
   end

   assign w_change   = r_q ^ r_q_prev;
   assign w_single   = ^w_change;
   assign w_illegal  = &w_change;
   assign w_up       = (gray_pos(r_q) == gray_pos(r_q_prev) + 2'd1);
   assign w_sub_step = w_up ? 4'sd1 : -4'sd1;
   assign w_sub_next = r_sub + w_sub_step;
   assign w_mode_chg = (bus.i_mode != r_mode);

   // Transition decode: count event and next sub-step accumulator
   // NOTE: every variable gets a default first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      w_event = 1'b0;
      w_sub_d = r_sub;
      if (w_illegal) begin
         w_sub_d = '0;
      end else if (w_single) begin
         case (r_mode)
            2'd0: begin
               w_sub_d = w_sub_next;
               if (r_q == 2'b11) begin
                  w_sub_d = '0;
                  w_event = (w_sub_next == 4'sd4) || (w_sub_next == -4'sd4);
               end
            end
            2'd1: begin
               w_sub_d = w_sub_next;
               if (r_q == 2'b11 || r_q == 2'b00) begin
                  w_sub_d = '0;
                  w_event = (w_sub_next == 4'sd2) || (w_sub_next == -4'sd2);
               end
            end
            default: begin
               w_sub_d = '0;
               w_event = 1'b1;
            end
         endcase
      end
      if (w_mode_chg) w_sub_d = '0;
   end

   // Next position: wrap or clamp to [0, MAX_COUNT]
   always_comb begin
      w_count_next = r_count;
      if (w_up) begin
         if (SATURATE != 0 && r_count >= MAX_C) w_count_next = MAX_C;
         else                                   w_count_next = r_count + COUNT_W'(1);
      end else begin
         if (SATURATE != 0 && r_count == '0)    w_count_next = '0;
         else                                   w_count_next = r_count - COUNT_W'(1);
      end
   end

   // Position, pulses and sticky error; clear overrides a same-cycle event
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
         r_step  <= 1'b0;
         r_dir   <= 1'b0;
         r_press <= 1'b0;
         r_err   <= 1'b0;
         r_sub   <= '0;
      end else begin
         r_step  <= 1'b0;
         r_press <= r_btn_prev & ~r_btn_q;
         if (bus.i_clr) begin
            r_count <= '0;
            r_sub   <= '0;
            r_err   <= 1'b0;
         end else begin
            r_sub <= w_sub_d;
            if (w_illegal) r_err <= 1'b1;
            if (w_event) begin
               r_step  <= 1'b1;
               r_dir   <= w_up;
               r_count <= w_count_next;
            end
         end
      end
   end

   assign bus.o_count     = r_count;
   assign bus.o_step      = r_step;
   assign bus.o_dir       = r_dir;
   assign bus.o_btn_press = r_press;
   assign bus.o_err       = r_err;
endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench: a wrapping and a saturating (MAX_COUNT=5) decoder share the
// same pin stimulus; expected values are hand-computed per step.
module tb_quad_encoder_counter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       pa, pb, pbtn, clr;
   logic [1:0] mode;
   int         n_total = 0;
   int         n_bad   = 0;
   int         steps0  = 0;
   int         steps1  = 0;
   int         press0  = 0;

   quad_encoder_counter_if #(.COUNT_W(4)) if0 ();
   quad_encoder_counter_if #(.COUNT_W(4)) if1 ();

   assign if0.i_a = pa;   assign if1.i_a = pa;
   assign if0.i_b = pb;   assign if1.i_b = pb;
   assign if0.i_btn = pbtn; assign if1.i_btn = pbtn;
   assign if0.i_mode = mode; assign if1.i_mode = mode;
   assign if0.i_clr = clr;  assign if1.i_clr = clr;

   quad_encoder_counter #(.COUNT_W(4), .DEB_CYCLES(4), .SATURATE(0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(if0)
   );
   quad_encoder_counter #(.COUNT_W(4), .DEB_CYCLES(4), .SATURATE(1), .MAX_COUNT(5)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(if1)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled 1 time unit after the active edge
   always begin
      @(posedge clk);
      #1;
      if (if0.o_step)      steps0 <= steps0 + 1;
      if (if1.o_step)      steps1 <= steps1 + 1;
      if (if0.o_btn_press) press0 <= press0 + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Drive a quadrature state and hold it long enough to be decoded
   task automatic ab(input logic a, input logic b);
      @(negedge clk);
      pa = a;
      pb = b;
      repeat (10) @(negedge clk);
   endtask

   task automatic seq_inc();
      ab(1'b1, 1'b0); ab(1'b0, 1'b0); ab(1'b0, 1'b1); ab(1'b1, 1'b1);
   endtask

   task automatic seq_dec();
      ab(1'b0, 1'b1); ab(1'b0, 1'b0); ab(1'b1, 1'b0); ab(1'b1, 1'b1);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic pulse_a(input int len);
      @(negedge clk);
      pa = 1'b0;
      repeat (len) @(negedge clk);
      pa = 1'b1;
      repeat (15) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; pa = 1'b1; pb = 1'b1; pbtn = 1'b1; clr = 1'b0; mode = 2'd2;
      repeat (3) @(negedge clk);
      check("rst_count", 32'(if0.o_count), 0);
      check("rst_step", 32'(if0.o_step), 0);
      check("rst_dir", 32'(if0.o_dir), 0);
      check("rst_press", 32'(if0.o_btn_press), 0);
      check("rst_err", 32'(if0.o_err), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // x4 increment; first transition checked for k+7 latency
      pb = 1'b0;
      @(posedge clk);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("lat_k6_count", 32'(if0.o_count), 0);
      @(posedge clk);
      @(negedge clk);
      check("lat_k7_count", 32'(if0.o_count), 1);
      check("lat_k7_step", 32'(if0.o_step), 1);
      repeat (8) @(negedge clk);
      ab(1'b0, 1'b0); ab(1'b0, 1'b1); ab(1'b1, 1'b1);
      check("x4_inc_count0", 32'(if0.o_count), 4);
      check("x4_inc_count1", 32'(if1.o_count), 4);
      check("x4_inc_steps", 32'(steps0), 4);
      check("x4_inc_dir", 32'(if0.o_dir), 1);

      pulse_clr();
      check("clr_count", 32'(if0.o_count), 0);

      // x1 decrement from 0 wraps to 15 with a single event
      @(negedge clk); mode = 2'd0;
      repeat (3) @(negedge clk);
      seq_dec();
      check("x1_dec_count0", 32'(if0.o_count), 15);
      check("x1_dec_count1", 32'(if1.o_count), 0);
      check("x1_dec_steps", 32'(steps0), 5);
      check("x1_dec_steps1", 32'(steps1), 5);
      check("x1_dec_dir", 32'(if0.o_dir), 0);
      ab(1'b1, 1'b0); ab(1'b1, 1'b1);
      check("x1_partial_count", 32'(if0.o_count), 15);
      check("x1_partial_steps", 32'(steps0), 5);

      // Debounce boundary in x4: 3-cycle glitch ignored, 4-cycle pulse accepted
      @(negedge clk); mode = 2'd2;
      repeat (3) @(negedge clk);
      pulse_a(3);
      check("glitch3_steps", 32'(steps0), 5);
      check("glitch3_count", 32'(if0.o_count), 15);
      pulse_a(4);
      check("pulse4_steps", 32'(steps0), 7);
      check("pulse4_count0", 32'(if0.o_count), 15);
      check("pulse4_count1", 32'(if1.o_count), 1);
      check("pulse4_dir", 32'(if0.o_dir), 1);

      // Saturation at both bounds
      pulse_clr();
      seq_dec();
      check("sat_dec_count1", 32'(if1.o_count), 0);
      check("sat_dec_count0", 32'(if0.o_count), 12);
      check("sat_dec_steps1", 32'(steps1), 11);
      seq_inc(); seq_inc();
      check("sat_inc_count1", 32'(if1.o_count), 5);
      check("wrap_inc_count0", 32'(if0.o_count), 4);
      check("sat_inc_steps1", 32'(steps1), 19);

      // Illegal transition and clear
      ab(1'b0, 1'b0);
      check("ill_err0", 32'(if0.o_err), 1);
      check("ill_count0", 32'(if0.o_count), 4);
      check("ill_count1", 32'(if1.o_count), 5);
      check("ill_steps", 32'(steps0), 19);
      ab(1'b1, 1'b1);
      pulse_clr();
      check("clr_err", 32'(if0.o_err), 0);
      check("clr_count0", 32'(if0.o_count), 0);

      // Clear coincident with an event wins
      ab(1'b1, 1'b0);
      check("pre_clr_count", 32'(if0.o_count), 1);
      @(negedge clk);
      pa = 1'b0;
      @(posedge clk);
      repeat (6) @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_ev_count", 32'(if0.o_count), 0);
      check("clr_ev_step", 32'(if0.o_step), 0);
      repeat (8) @(negedge clk);
      check("clr_ev_steps", 32'(steps0), 20);

      // Build up count 5 and a set error flag
      ab(1'b0, 1'b1); ab(1'b1, 1'b1);
      seq_inc();
      ab(1'b0, 1'b1);
      check("pre_rst_count0", 32'(if0.o_count), 5);
      check("pre_rst_count1", 32'(if1.o_count), 4);
      ab(1'b1, 1'b0);
      check("pre_rst_err", 32'(if0.o_err), 1);

      // Button press
      @(negedge clk);
      pbtn = 1'b0;
      repeat (10) @(negedge clk);
      pbtn = 1'b1;
      repeat (12) @(negedge clk);
      check("btn_press_cnt", 32'(press0), 1);

      // Asynchronous reset between edges
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_count", 32'(if0.o_count), 0);
      check("async_rst_err", 32'(if0.o_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
